// File: rtl/home_automation_scan_controller.sv
// Round-robin scan controller for home automation actuators.
// Arbitrates the digital sensor requests and the heat/cool requests derived
// from temperature, holds each grant for a minimum dwell time, and lets a
// sticky alarm channel preempt whatever is being served.
//
// Handshake: none. Every input is sampled on the rising clock edge, and every
// output is registered and changes only on that edge or on reset.
module home_automation_scan_controller #(
    parameter int N_SENSORS = 5,
    parameter int TEMP_W    = 6,
    parameter int T_LOW     = 15,
    parameter int T_HIGH    = 30,
    parameter int HYST      = 2,
    parameter int DWELL     = 4,
    parameter int ALARM_CH  = 2,
    localparam int IDX_W    = $clog2(N_SENSORS + 2)
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [N_SENSORS-1:0]   sensor,
    input  logic [TEMP_W-1:0]      temperature,
    input  logic                   alarm_ack,
    output logic [N_SENSORS+1:0]   actuator,
    output logic [IDX_W-1:0]       display,
    output logic                   active,
    output logic                   alarm_latched
);

    localparam int NCH   = N_SENSORS + 2;
    localparam int CNT_W = (DWELL > 1) ? $clog2(DWELL) : 1;

    localparam logic [TEMP_W-1:0] HEAT_ON  = TEMP_W'(T_LOW);
    localparam logic [TEMP_W-1:0] HEAT_OFF = TEMP_W'(T_LOW + HYST);
    localparam logic [TEMP_W-1:0] COOL_ON  = TEMP_W'(T_HIGH);
    localparam logic [TEMP_W-1:0] COOL_OFF = TEMP_W'(T_HIGH - HYST);
    localparam logic [IDX_W-1:0]  LAST_IDX  = IDX_W'(NCH - 1);
    localparam logic [IDX_W-1:0]  ALARM_IDX = IDX_W'(ALARM_CH);
    localparam logic [CNT_W-1:0]  DWELL_LOAD = CNT_W'(DWELL - 1);
    localparam logic [NCH-1:0]    ONE_HOT0  = NCH'(1);

    // Overlapping hysteresis bands would let heat and cool fight each other.
    if (T_LOW + HYST > T_HIGH - HYST) begin : g_bad_thresholds
        $error("home_automation_scan_controller: T_LOW+HYST must not exceed T_HIGH-HYST");
    end

    typedef enum logic {SCAN, SERVE} state_t;

    state_t              state_q, state_d;
    logic                heat_req_q, heat_req_d;
    logic                cool_req_q, cool_req_d;
    logic                alarm_q, alarm_d;
    logic [IDX_W-1:0]    ptr_q, ptr_d;
    logic [IDX_W-1:0]    grant_q, grant_d;
    logic [CNT_W-1:0]    dwell_q, dwell_d;
    logic [NCH-1:0]      actuator_q, actuator_d;
    logic [IDX_W-1:0]    display_q, display_d;
    logic                active_q, active_d;
    logic [NCH-1:0]      req;
    logic                others_pending;
    logic                preempt;
    logic                release_ok;

    function automatic logic [IDX_W-1:0] next_idx(input logic [IDX_W-1:0] idx);
        return (idx == LAST_IDX) ? '0 : idx + IDX_W'(1);
    endfunction

    // Heat/cool requests with hysteresis, and the sticky alarm latch (set wins).
    always_comb begin
        heat_req_d = heat_req_q;
        cool_req_d = cool_req_q;
        alarm_d    = alarm_q;
        if (temperature < HEAT_ON) begin
            heat_req_d = 1'b1;
        end else if (temperature >= HEAT_OFF) begin
            heat_req_d = 1'b0;
        end
        if (temperature > COOL_ON) begin
            cool_req_d = 1'b1;
        end else if (temperature <= COOL_OFF) begin
            cool_req_d = 1'b0;
        end
        if (sensor[ALARM_CH]) begin
            alarm_d = 1'b1;
        end else if (alarm_ack) begin
            alarm_d = 1'b0;
        end
    end

    // Request vector: the latched alarm stands in for the raw alarm sensor.
    always_comb begin
        req            = {cool_req_q, heat_req_q, sensor};
        req[ALARM_CH]  = alarm_q;
        others_pending = |(req & ~(ONE_HOT0 << grant_q));
        preempt        = alarm_q && !((state_q == SERVE) && (grant_q == ALARM_IDX));
        // The alarm grant waits for the acknowledge; other grants yield to
        // competing requests once their dwell is over.
        if (grant_q == ALARM_IDX) begin
            release_ok = (dwell_q == '0) && !alarm_q;
        end else begin
            release_ok = (dwell_q == '0) && (!req[grant_q] || others_pending);
        end
    end

    // Scan/serve arbitration with alarm preemption.
    always_comb begin
        state_d    = state_q;
        ptr_d      = ptr_q;
        grant_d    = grant_q;
        dwell_d    = dwell_q;
        actuator_d = actuator_q;
        display_d  = display_q;
        active_d   = active_q;
        if (preempt) begin
            state_d    = SERVE;
            grant_d    = ALARM_IDX;
            dwell_d    = DWELL_LOAD;
            actuator_d = ONE_HOT0 << ALARM_IDX;
            display_d  = ALARM_IDX;
            active_d   = 1'b1;
        end else if (state_q == SCAN) begin
            if (req[ptr_q]) begin
                state_d    = SERVE;
                grant_d    = ptr_q;
                dwell_d    = DWELL_LOAD;
                actuator_d = ONE_HOT0 << ptr_q;
                display_d  = ptr_q;
                active_d   = 1'b1;
            end else begin
                ptr_d = next_idx(ptr_q);
            end
        end else begin
            if (dwell_q != '0) begin
                dwell_d = dwell_q - CNT_W'(1);
            end else if (release_ok) begin
                state_d    = SCAN;
                ptr_d      = next_idx(grant_q);
                actuator_d = '0;
                active_d   = 1'b0;
            end
        end
    end

    // State and output registers; reset drops the actuators at once.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= SCAN;
            heat_req_q <= 1'b0;
            cool_req_q <= 1'b0;
            alarm_q    <= 1'b0;
            ptr_q      <= '0;
            grant_q    <= '0;
            dwell_q    <= '0;
            actuator_q <= '0;
            display_q  <= '0;
            active_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            heat_req_q <= heat_req_d;
            cool_req_q <= cool_req_d;
            alarm_q    <= alarm_d;
            ptr_q      <= ptr_d;
            grant_q    <= grant_d;
            dwell_q    <= dwell_d;
            actuator_q <= actuator_d;
            display_q  <= display_d;
            active_q   <= active_d;
        end
    end

    assign actuator      = actuator_q;
    assign display       = display_q;
    assign active        = active_q;
    assign alarm_latched = alarm_q;

endmodule

// File: tb/tb_home_automation_scan_controller.sv
// Bench for home_automation_scan_controller: directed scenarios followed by
// random sensor/temperature/ack traffic, all outputs compared every cycle
// against a behavioural model of the arbitration rules.
module tb_home_automation_scan_controller;
  localparam int NS    = 5;
  localparam int NCH   = NS + 2;
  localparam int TW    = 6;
  localparam int IW    = 3;
  localparam int ALARM = 2;
  localparam int DW    = 4;

  logic          clk;
  logic          reset;
  logic [NS-1:0] sensor;
  logic [TW-1:0] temperature;
  logic          alarm_ack;
  logic [NCH-1:0] actuator;
  logic [IW-1:0] display;
  logic          active;
  logic          alarm_latched;

  int n_checks;
  int n_fail;
  bit chk_en;

  home_automation_scan_controller dut (
    .clk(clk), .reset(reset), .sensor(sensor), .temperature(temperature),
    .alarm_ack(alarm_ack), .actuator(actuator), .display(display),
    .active(active), .alarm_latched(alarm_latched)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %0h expected %0h", tag, $time, got, exp);
    end
  endtask

  // behavioural model: serving flag, granted channel, cycles still owed
  int m_heat, m_cool, m_alarm, m_ptr, m_serving, m_grant, m_left, m_disp;
  logic [NCH-1:0] m_req;
  bit m_others, m_rel;
  int t;

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_heat = 0; m_cool = 0; m_alarm = 0; m_ptr = 0;
      m_serving = 0; m_grant = 0; m_left = 0; m_disp = 0;
    end else begin
      m_req = {m_cool[0], m_heat[0], sensor};
      m_req[ALARM] = m_alarm[0];
      m_others = 1'b0;
      for (int c = 0; c < NCH; c++) if (c != m_grant && m_req[c]) m_others = 1'b1;
      if (m_alarm == 1 && !(m_serving == 1 && m_grant == ALARM)) begin
        m_serving = 1; m_grant = ALARM; m_left = DW - 1; m_disp = ALARM;
      end else if (m_serving == 0) begin
        if (m_req[m_ptr]) begin
          m_serving = 1; m_grant = m_ptr; m_left = DW - 1; m_disp = m_ptr;
        end else begin
          m_ptr = (m_ptr + 1) % NCH;
        end
      end else if (m_left > 0) begin
        m_left = m_left - 1;
      end else begin
        if (m_grant == ALARM) m_rel = (m_alarm == 0);
        else m_rel = !m_req[m_grant] || m_others;
        if (m_rel) begin
          m_serving = 0;
          m_ptr = (m_grant + 1) % NCH;
        end
      end
      t = int'(temperature);
      if (t < 15) m_heat = 1; else if (t >= 17) m_heat = 0;
      if (t > 30) m_cool = 1; else if (t <= 28) m_cool = 0;
      if (sensor[ALARM]) m_alarm = 1; else if (alarm_ack) m_alarm = 0;
    end
  end

  // scoreboard: compare every output on the falling edge
  always @(negedge clk) begin
    if (!reset && chk_en) begin
      check("actuator", 32'(actuator), (m_serving == 1) ? (32'd1 << m_grant) : 32'd0);
      check("display", 32'(display), 32'(m_disp));
      check("active", 32'(active), 32'(m_serving));
      check("alarm_latched", 32'(alarm_latched), 32'(m_alarm));
    end
  end

  // driver tasks
  task automatic run(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wait_active(input int max_cycles);
    for (int k = 0; k < max_cycles; k++) begin
      @(negedge clk);
      if (active) break;
    end
    check("grant_seen", 32'(active), 32'd1);
  endtask

  task automatic do_reset();
    @(negedge clk);
    #2 reset = 1'b1;
    #1;
    check("reset_actuator", 32'(actuator), 32'd0);
    check("reset_display", 32'(display), 32'd0);
    check("reset_active", 32'(active), 32'd0);
    check("reset_alarm", 32'(alarm_latched), 32'd0);
    @(negedge clk);
    #2 reset = 1'b0;
  endtask

  initial begin
    n_checks = 0; n_fail = 0; chk_en = 1'b1;
    reset = 1'b1; sensor = '0; temperature = 6'd20; alarm_ack = 1'b0;
    run(3);
    #2 reset = 1'b0;

    // idle scan
    run(12);

    // single sensor, dropped after one served cycle
    sensor = 5'b00001;
    wait_active(10);
    check("grant_ch0", 32'(actuator), 32'h01);
    @(negedge clk); sensor = '0;
    run(8);

    // two sensors alternate
    sensor = 5'b01001;
    run(30);
    sensor = '0;
    run(8);

    // temperature driven heat and cool
    temperature = 6'd14; run(8);
    check("heater_on", 32'(actuator), 32'h20);
    temperature = 6'd16; run(6);
    check("heater_hold", 32'(actuator), 32'h20);
    temperature = 6'd17; run(8);
    temperature = 6'd31; run(8);
    check("cooler_on", 32'(actuator), 32'h40);
    temperature = 6'd29; run(6);
    check("cooler_hold", 32'(actuator), 32'h40);
    temperature = 6'd28; run(8);
    temperature = 6'd20; run(4);

    // alarm preempts a served sensor
    sensor = 5'b00001;
    wait_active(10);
    sensor = 5'b00101; @(negedge clk);
    sensor = 5'b00001; run(2);
    check("alarm_grant", 32'(actuator), 32'h04);
    run(6);
    alarm_ack = 1'b1; @(negedge clk);
    alarm_ack = 1'b0; run(10);
    sensor = '0; run(10);

    // ack and alarm together: set wins
    sensor = 5'b00100; alarm_ack = 1'b1; @(negedge clk);
    sensor = '0; alarm_ack = 1'b0; run(1);
    check("alarm_set_wins", 32'(alarm_latched), 32'd1);
    run(6);
    alarm_ack = 1'b1; @(negedge clk);
    alarm_ack = 1'b0; run(8);

    // reset in the middle of a grant
    sensor = 5'b00010;
    wait_active(10);
    do_reset();
    sensor = '0;
    run(4);

    // random traffic
    for (int i = 0; i < 3000; i++) begin
      logic [NS-1:0] s;
      int tv;
      @(negedge clk);
      for (int b = 0; b < NS; b++)
        s[b] = (b == ALARM) ? ($urandom_range(40) == 0) : ($urandom_range(5) == 0);
      sensor = s;
      alarm_ack = ($urandom_range(7) == 0);
      tv = int'(temperature);
      if ($urandom_range(30) == 0) tv = $urandom_range(63);
      else tv = tv + $urandom_range(4) - 2;
      if (tv < 0) tv = 0;
      if (tv > 63) tv = 63;
      temperature = 6'(tv);
      if (i == 1500) do_reset();
    end
    run(4);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
